fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that owns the program counter and consumes branch redirects from branch resolution.
- Issues one instruction-memory request at a time, advances PC by 4 and delivers {instr, pc, pc+4} to the IF/ID boundary.
- Honours hazard-unit stalls and squashes wrong-path fetches whenever a redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, value driven on if_instr when no valid instruction

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID outputs, no advance
redirect_valid  input  1  taken branch/jump resolved this cycle
redirect_target  input  32  new PC when redirect_valid=1
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  request byte address (= pc)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (one per accepted request, >=1 cycle later)
imem_rdata  input  32  instruction word
if_valid  output  1  IF/ID holds a valid instruction
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr
if_pcp4  output  32  if_pc + 4
misalign_fault  output  1  see Optional Feature

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, squash=0, hold buffer empty.
- Output reset values: imem_req=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pcp4=0, misalign_fault=0.
- Single clock domain; reset applies only on a clk edge and overrides every other input. Reset mid-transaction abandons the outstanding request; any later rvalid is ignored while in IDLE.
- At most one outstanding request; imem_addr=pc whenever imem_req=1.
- States:
  - IDLE: imem_req=0; always goes to REQ next cycle.
  - REQ: imem_req=1. imem_ready=1 -> WAIT. imem_ready=0 -> stay in REQ; address may change only because of a redirect.
  - WAIT: imem_req=0. rvalid=1 with squash=1 -> drop data, squash<=0, go REQ. rvalid=1 with squash=0 and stall=0 -> load IF/ID, pc<=pc+4, go REQ. rvalid=1 with squash=0 and stall=1 -> capture into hold buffer, go HOLD.
  - HOLD: imem_req=0. When stall=0 -> load IF/ID from hold buffer, pc<=pc+4, go REQ.
- IF/ID load: if_instr=data, if_pc=pc, if_pcp4=pc+4, if_valid=1. Arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 = 0.
- If stall=0 and nothing loads this cycle: if_valid<=0 and if_instr<=NOP_INSTR (bubble). If stall=1: IF/ID registers hold.
- Redirect has priority over stall and over normal advance:
  - pc<=redirect_target; if_valid<=0; hold buffer cleared.
  - In REQ with imem_ready=0: stay in REQ at the new pc.
  - In REQ with imem_ready=1: the old request is accepted; go WAIT with squash=1.
  - In WAIT without rvalid: squash<=1.
  - In WAIT with rvalid the same cycle: drop the data, go REQ.
  - In HOLD: go REQ.
  - In IDLE: only pc is updated.
- Throughput: one instruction per 2 cycles minimum, given ready=1 and 1-cycle rvalid.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 sets misalign_fault=1 (sticky) and enters FAULT.
  - FAULT: imem_req=0, if_valid=0, all inputs ignored; exits only on rst.
  - An outstanding response is discarded.
- Undefined:
  - pc<=redirect_target with bits [1:0] forced to 00.
  - misalign_fault tied 0; no FAULT state exists.

Test Plan:
- Reset release, ready=1, rvalid 1 cycle after accept, rdata=0x2002_0005: imem_addr 0x0, then 0x4; if_valid=1, if_pc=0x0, if_pcp4=0x4, if_instr=0x2002_0005.
- stall=1 when rvalid arrives for pc=0x8: IF/ID keeps the previous instruction. Release stall: if_pc=0x8 appears next cycle; next imem_addr=0xC.
- redirect_valid=1, target=0x40, in WAIT for pc=0x10: the 0x10 response is dropped and never appears on if_*. Next imem_addr=0x40; if_valid=0 in the redirect cycle.
- Redirect and imem_ready=1 in the same REQ cycle (pc=0x20, target=0x100): the 0x20 data is squashed; the next request is 0x100.
- RESET_PC=0xFFFF_FFFC: first fetch if_pcp4=0x0; second imem_addr=0x0.
- With FETCH_ALIGN_CHECK_EN, target=0x42: misalign_fault=1 next cycle, imem_req stays 0 until rst. Without the macro: imem_addr=0x40, misalign_fault=0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Instruction-memory request/response bus between the fetch stage and
//   instruction memory. One request may be outstanding at a time.
//
//   req     master -> slave  request valid
//   addr    master -> slave  request byte address
//   ready   slave  -> master request accepted this cycle
//   rvalid  slave  -> master read data valid (one per accepted request)
//   rdata   slave  -> master instruction word
interface fetch_pc_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Instruction-fetch stage. Owns the program counter, issues one
//   instruction-memory request at a time, and delivers {instr, pc, pc+4}
//   to the IF/ID boundary. Honours hazard stalls and squashes wrong-path
//   fetches when a branch redirect arrives.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   stall            hold IF/ID outputs, no advance
//   redirect_valid   taken branch/jump resolved this cycle
//   redirect_target  new PC when redirect_valid=1
//   imem             instruction-memory bus (master side)
//   if_valid         IF/ID holds a valid instruction
//   if_instr         fetched instruction (NOP_INSTR when not valid)
//   if_pc            address of if_instr
//   if_pcp4          if_pc + 4
//   misalign_fault   sticky misaligned-redirect flag
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned
//   target raises misalign_fault and parks the unit in FAULT until reset.
//   When undefined, the target's low two bits are cleared and
//   misalign_fault is tied low.
//
// State | Meaning
// IDLE  | after reset; no request, moves to REQ next cycle
// REQ   | imem.req=1 at pc, waiting for imem.ready
// WAIT  | request accepted, waiting for imem.rvalid
// HOLD  | response captured while stalled; waiting for stall to drop
// FAULT | misaligned redirect seen (alignment check builds only)
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  fetch_pc_unit_if.master        imem,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_pcp4,
  output logic                   misalign_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    FAULT = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [31:0] hold_q, hold_d;

  logic        load;
  logic [31:0] load_data;
  logic        flush;
  logic        in_fault;

  logic        if_valid_d;
  logic [31:0] if_instr_d;
  logic [31:0] if_pc_d;
  logic [31:0] if_pcp4_d;

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign misalign_fault = fault_q;
  assign in_fault       = (state_q == FAULT);
`else
  assign misalign_fault = 1'b0;
  assign in_fault       = 1'b0;
`endif

  // Request is a pure function of state; the address always tracks pc so
  // it can only move while in REQ through a redirect.
  assign imem.req  = (state_q == REQ);
  assign imem.addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;
    flush     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else if (!stall) begin
            load      = 1'b1;
            load_data = imem.rdata;
            pc_d      = pc_plus4;
            state_d   = REQ;
          end else begin
            hold_d  = imem.rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_data = hold_q;
          pc_d      = pc_plus4;
          state_d   = REQ;
        end
      end
      default: state_d = state_q;
    endcase

    // Redirect overrides normal advance and stall. The in-flight request
    // (if any) cannot be cancelled, so its response is marked for dropping.
    if (redirect_valid && !in_fault) begin
      load   = 1'b0;
      flush  = 1'b1;
      hold_d = NOP_INSTR;
      pc_d   = redirect_target & ~32'h0000_0003;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem.ready) begin
            state_d  = WAIT;
            squash_d = 1'b1;
          end else begin
            state_d  = REQ;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            state_d  = REQ;
            squash_d = 1'b0;
          end else begin
            state_d  = WAIT;
            squash_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = state_q;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_d  = FAULT;
        fault_d  = 1'b1;
        squash_d = 1'b0;
        pc_d     = pc_q;
      end
`endif
    end
  end

  // IF/ID next values: load wins, otherwise bubble when not stalled,
  // otherwise hold. Redirects and FAULT always kill the valid bit.
  always_comb begin
    if_valid_d = if_valid;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
    if_pcp4_d  = if_pcp4;
    if (load) begin
      if_valid_d = 1'b1;
      if_instr_d = load_data;
      if_pc_d    = pc_q;
      if_pcp4_d  = pc_plus4;
    end else begin
      if (!stall) begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
      if (flush || in_fault) if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      hold_q   <= NOP_INSTR;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= 32'h0000_0000;
      if_pcp4  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      hold_q   <= hold_d;
      if_valid <= if_valid_d;
      if_instr <= if_instr_d;
      if_pc    <= if_pc_d;
      if_pcp4  <= if_pcp4_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  localparam logic [31:0] N = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        stall, rv, stall2, rv2;
  logic [31:0] tgt, tgt2;
  logic        if_valid, if_valid2;
  logic [31:0] if_instr, if_pc, if_pcp4, if_instr2, if_pc2, if_pcp42;
  logic        fault, fault2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if bus0 ();
  fetch_pc_unit_if bus1 ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(N)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv),
    .redirect_target(tgt), .imem(bus0), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pcp4(if_pcp4),
    .misalign_fault(fault)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(stall2), .redirect_valid(rv2),
    .redirect_target(tgt2), .imem(bus1), .if_valid(if_valid2),
    .if_instr(if_instr2), .if_pc(if_pc2), .if_pcp4(if_pcp42),
    .misalign_fault(fault2)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pcp4;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic rdy,
                              logic rvl, logic [31:0] rd, logic ereq,
                              logic [31:0] eaddr, logic evld, logic [31:0] ein,
                              logic [31:0] epc, logic [31:0] ep4, logic ef);
    vec_t v;
    v.stall = s;  v.rv = r;  v.tgt = t;  v.ready = rdy;  v.rvalid = rvl;
    v.rdata = rd; v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evld;
    v.e_instr = ein; v.e_pc = epc; v.e_pcp4 = ep4; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = '0;
    bus0.ready = 1'b0; bus0.rvalid = 1'b0; bus0.rdata = '0;
    rst2 = 1'b1; stall2 = 1'b0; rv2 = 1'b0; tgt2 = '0;
    bus1.ready = 1'b0; bus1.rvalid = 1'b0; bus1.rdata = '0;

    // Each row: inputs driven this cycle, outputs observed this cycle
    // (if_* reflect the previous edge; req/addr reflect current state).
    //              stl rv tgt         rdy rvl rdata          req addr        vld instr          pc          pcp4        flt
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         0, 32'h0,     0, N,             32'h0,     32'h0,     0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h0,     0, N,             32'h0,     32'h0,     0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h2002_0005, 0, 32'h0,     0, N,             32'h0,     32'h0,     0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h4,     1, 32'h2002_0005, 32'h0,     32'h4,     0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'hAAAA_0001, 0, 32'h4,     0, N,             32'h0,     32'h4,     0));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 32'h0,         1, 32'h8,     1, 32'hAAAA_0001, 32'h4,     32'h8,     0));
    vecs.push_back(mk(1, 0, 32'h0,     0, 1, 32'hBBBB_0002, 0, 32'h8,     1, 32'hAAAA_0001, 32'h4,     32'h8,     0));
    vecs.push_back(mk(1, 0, 32'h0,     0, 0, 32'h0,         0, 32'h8,     1, 32'hAAAA_0001, 32'h4,     32'h8,     0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         0, 32'h8,     1, 32'hAAAA_0001, 32'h4,     32'h8,     0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         1, 32'hC,     1, 32'hBBBB_0002, 32'h8,     32'hC,     0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'hC,     0, N,             32'h8,     32'hC,     0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'hCCCC_0003, 0, 32'hC,     0, N,             32'h8,     32'hC,     0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h10,    1, 32'hCCCC_0003, 32'hC,     32'h10,    0));
    vecs.push_back(mk(0, 1, 32'h40,    0, 0, 32'h0,         0, 32'h10,    0, N,             32'hC,     32'h10,    0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'hDEAD_0010, 0, 32'h40,    0, N,             32'hC,     32'h10,    0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h40,    0, N,             32'hC,     32'h10,    0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h4444_0040, 0, 32'h40,    0, N,             32'hC,     32'h10,    0));
    vecs.push_back(mk(0, 1, 32'h100,   1, 0, 32'h0,         1, 32'h44,    1, 32'h4444_0040, 32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h5555_0044, 0, 32'h100,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h100,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 1, 32'h200,   0, 1, 32'h6666_0100, 0, 32'h100,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 1, 32'h300,   0, 0, 32'h0,         1, 32'h200,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h300,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h7777_0300, 0, 32'h300,   0, N,             32'h40,    32'h44,    0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         1, 32'h304,   1, 32'h7777_0300, 32'h300,   32'h304,   0));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 32'h0,         1, 32'h304,   0, N,             32'h300,   32'h304,   0));
    vecs.push_back(mk(1, 0, 32'h0,     0, 1, 32'h8888_0304, 0, 32'h304,   0, N,             32'h300,   32'h304,   0));
    vecs.push_back(mk(1, 1, 32'h42,    0, 0, 32'h0,         0, 32'h304,   0, N,             32'h300,   32'h304,   0));
`ifdef FETCH_ALIGN_CHECK_EN
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         0, 32'h304,   0, N,             32'h300,   32'h304,   1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h9999_0040, 0, 32'h304,   0, N,             32'h300,   32'h304,   1));
    vecs.push_back(mk(0, 1, 32'h80,    1, 0, 32'h0,         0, 32'h304,   0, N,             32'h300,   32'h304,   1));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         0, 32'h304,   0, N,             32'h300,   32'h304,   1));
`else
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h0,         1, 32'h40,    0, N,             32'h300,   32'h304,   0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h9999_0040, 0, 32'h40,    0, N,             32'h300,   32'h304,   0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,         1, 32'h44,    1, 32'h9999_0040, 32'h40,    32'h44,    0));
`endif

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      stall = vecs[i].stall; rv = vecs[i].rv; tgt = vecs[i].tgt;
      bus0.ready = vecs[i].ready; bus0.rvalid = vecs[i].rvalid;
      bus0.rdata = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d imem_req", i),  {31'b0, bus0.req}, {31'b0, vecs[i].e_req});
      chk($sformatf("row%0d imem_addr", i), bus0.addr,         vecs[i].e_addr);
      chk($sformatf("row%0d if_valid", i),  {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("row%0d if_instr", i),  if_instr,          vecs[i].e_instr);
      chk($sformatf("row%0d if_pc", i),     if_pc,             vecs[i].e_pc);
      chk($sformatf("row%0d if_pcp4", i),   if_pcp4,           vecs[i].e_pcp4);
      chk($sformatf("row%0d misalign", i),  {31'b0, fault},    {31'b0, vecs[i].e_fault});
    end

    // Reset while busy clears everything, including a sticky fault.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; rv = 1'b0; bus0.ready = 1'b0; bus0.rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst imem_req",  {31'b0, bus0.req}, 32'd0);
    chk("rst imem_addr", bus0.addr,         32'h0);
    chk("rst if_valid",  {31'b0, if_valid}, 32'd0);
    chk("rst if_instr",  if_instr,          N);
    chk("rst if_pc",     if_pc,             32'h0);
    chk("rst misalign",  {31'b0, fault},    32'd0);
    @(negedge clk);
    #1;
    chk("post-rst imem_req", {31'b0, bus0.req}, 32'd1);

    // PC wrap from 0xFFFF_FFFC to 0.
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("wrap idle req",  {31'b0, bus1.req}, 32'd0);
    chk("wrap idle addr", bus1.addr,         32'hFFFF_FFFC);
    @(negedge clk);
    bus1.ready = 1'b1;
    #1;
    chk("wrap req1",  {31'b0, bus1.req}, 32'd1);
    chk("wrap addr1", bus1.addr,         32'hFFFF_FFFC);
    @(negedge clk);
    bus1.ready = 1'b0; bus1.rvalid = 1'b1; bus1.rdata = 32'h1111_2222;
    #1;
    chk("wrap wait req", {31'b0, bus1.req}, 32'd0);
    @(negedge clk);
    bus1.rvalid = 1'b0;
    #1;
    chk("wrap req2",     {31'b0, bus1.req}, 32'd1);
    chk("wrap addr2",    bus1.addr,         32'h0);
    chk("wrap if_valid", {31'b0, if_valid2}, 32'd1);
    chk("wrap if_instr", if_instr2,         32'h1111_2222);
    chk("wrap if_pc",    if_pc2,            32'hFFFF_FFFC);
    chk("wrap if_pcp4",  if_pcp42,          32'h0);
    chk("wrap misalign", {31'b0, fault2},   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
